// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low gfedcba glyphs,
// error-cause encodings, monitor FSM states and a small anode helper.
package seg_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
    localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
    localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
    localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
    localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
    localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0011000;
    localparam logic [6:0] SEG_PAT_A = 7'b0001000;
    localparam logic [6:0] SEG_PAT_B = 7'b0000011;
    localparam logic [6:0] SEG_PAT_C = 7'b1000110;
    localparam logic [6:0] SEG_PAT_D = 7'b0100001;
    localparam logic [6:0] SEG_PAT_E = 7'b0000110;
    localparam logic [6:0] SEG_PAT_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_UNKNOWN = 2'b01,
        ERR_MULTI   = 2'b10
    } err_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } scan_state_e;

    // Number of active (low) anodes on the bus.
    function automatic logic [2:0] count_low(input logic [3:0] an);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph decoder: active-low gfedcba pattern -> {known, blank, hex value}.
// Kept standalone so display drivers can share the same glyph table.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       known_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        // NOTE: every output is given a default before the case, so no path can infer a latch.
        known_o = 1'b1;
        value_o = 4'h0;
        blank_o = (pattern_i == SEG_BLANK);
        case (pattern_i)
            SEG_PAT_0: value_o = 4'h0;
            SEG_PAT_1: value_o = 4'h1;
            SEG_PAT_2: value_o = 4'h2;
            SEG_PAT_3: value_o = 4'h3;
            SEG_PAT_4: value_o = 4'h4;
            SEG_PAT_5: value_o = 4'h5;
            SEG_PAT_6: value_o = 4'h6;
            SEG_PAT_7: value_o = 4'h7;
            SEG_PAT_8: value_o = 4'h8;
            SEG_PAT_9: value_o = 4'h9;
            SEG_PAT_A: value_o = 4'hA;
            SEG_PAT_B: value_o = 4'hB;
            SEG_PAT_C: value_o = 4'hC;
            SEG_PAT_D: value_o = 4'hD;
            SEG_PAT_E: value_o = 4'hE;
            SEG_PAT_F: value_o = 4'hF;
            default:   known_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/segment_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit active-low seven-segment bus.
// Define SEGDEC_TIMEOUT_EN to age out digits that stop being refreshed.
module segment_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  upd_pulse,
    output logic        err_pulse,
    output logic [1:0]  err_cause
);

    localparam int SETTLE_SAT = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_SAT);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAT - 1);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > (1 << CNT_W) - 1) ||
        (SETTLE_SAT > (1 << CNT_W) - 1)) begin : g_bad_cfg
        $error("segment_scan_decoder: CNT_W too narrow for SETTLE_CYCLES/TIMEOUT_CYCLES");
    end

    logic [3:0]       s_an_q, p_an_q;
    logic [6:0]       s_seg_q, p_seg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_e      state_q, state_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       upd_q, upd_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;

    logic       changed, settled, one_low, multi_low;
    logic       capture, multi_err;
    logic [1:0] sel;
    logic [3:0] cap_onehot;
    logic [3:0] to_expire;
    logic       dec_known, dec_blank;
    logic [3:0] dec_value;

    seg_pattern_decode u_decode (
        .pattern_i (s_seg_q),
        .known_o   (dec_known),
        .blank_o   (dec_blank),
        .value_o   (dec_value)
    );

    // Bus sampling, stability counter and FSM sequencing.
    always_comb begin
        changed   = ({s_an_q, s_seg_q} != {p_an_q, p_seg_q});
        one_low   = (count_low(s_an_q) == 3'd1);
        multi_low = (count_low(s_an_q) >= 3'd2);
        settled   = !changed && (cnt_q == SETTLE_LAST);
        cnt_d     = changed ? '0 : ((cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + CNT_W'(1));

        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!s_an_q[i]) sel = 2'(i);
        end

        state_d   = state_q;
        capture   = 1'b0;
        multi_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                multi_err = multi_low && settled;
                if (one_low) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (changed) begin
                    state_d = one_low ? ST_SETTLE : ST_IDLE;
                end else if (one_low && settled) begin
                    capture = 1'b1;
                    state_d = ST_CAPTURED;
                end
            end
            ST_CAPTURED: begin
                if (changed) state_d = one_low ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cap_onehot = capture ? ~s_an_q : 4'b0000;
    end

    // Result registers; a capture overrides an expiry landing on the same cycle.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q & ~to_expire;
        upd_d    = 4'b0000;
        err_d    = 1'b0;
        cause_d  = cause_q;
        if (multi_err) begin
            err_d   = 1'b1;
            cause_d = ERR_MULTI;
        end else if (capture) begin
            if (dec_known) begin
                digits_d[{sel, 2'b00} +: 4] = dec_value;
                valid_d[sel]                = 1'b1;
                upd_d[sel]                  = 1'b1;
            end else if (dec_blank) begin
                valid_d[sel] = 1'b0;
            end else begin
                valid_d[sel] = 1'b0;
                err_d        = 1'b1;
                cause_d      = ERR_UNKNOWN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an_q   <= 4'hF;
            s_seg_q  <= SEG_BLANK;
            p_an_q   <= 4'hF;
            p_seg_q  <= SEG_BLANK;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            digits_q <= '0;
            valid_q  <= '0;
            upd_q    <= '0;
            err_q    <= 1'b0;
            cause_q  <= ERR_NONE;
        end else begin
            s_an_q   <= an;
            s_seg_q  <= seg;
            p_an_q   <= s_an_q;
            p_seg_q  <= s_seg_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
        end
    end

`ifdef SEGDEC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q [4];
    logic [CNT_W-1:0] to_cnt_d [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            to_expire[k] = !cap_onehot[k] && (to_cnt_q[k] == TIMEOUT_LAST);
            if (cap_onehot[k]) begin
                to_cnt_d[k] = '0;
            end else if (to_cnt_q[k] != TIMEOUT_MAX) begin
                to_cnt_d[k] = to_cnt_q[k] + CNT_W'(1);
            end else begin
                to_cnt_d[k] = to_cnt_q[k];
            end
        end
    end

    // NOTE: this counter array is tiny and must start from zero, so unlike a RAM it sits on the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) to_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) to_cnt_q[k] <= to_cnt_d[k];
        end
    end
`else
    assign to_expire = 4'b0000;
`endif

    assign digits    = digits_q;
    assign valid     = valid_q;
    assign upd_pulse = upd_q;
    assign err_pulse = err_q;
    assign err_cause = cause_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Scoreboard bench for segment_scan_decoder: expected capture/error events are queued
// when a dwell is driven and matched, cycle-exact, against the pulses the DUT emits.
module tb_segment_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  upd_pulse;
    logic        err_pulse;
    logic [1:0]  err_cause;

    always #5 clk = ~clk;

    segment_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (17)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .valid     (valid),
        .upd_pulse (upd_pulse),
        .err_pulse (err_pulse),
        .err_cause (err_cause)
    );

    typedef struct {
        bit         is_err;
        int         digit;
        logic [3:0] value;
        logic [1:0] cause;
        int         cyc;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [6:0] ref_pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic [3:0]  last_an;
    logic [6:0]  last_seg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        evt_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("evt_missing_by_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (upd_pulse != 4'b0000 || err_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", {25'd0, upd_pulse, err_pulse, err_cause}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
                check("evt_err_pulse", 32'(err_pulse), 32'(e.is_err));
                if (e.is_err) begin
                    check("evt_err_cause", 32'(err_cause), 32'(e.cause));
                    check("evt_no_upd_on_err", 32'(upd_pulse), 32'd0);
                end else begin
                    check("evt_upd_pulse", 32'(upd_pulse), 32'(1 << e.digit));
                    check("evt_digit_value", 32'(digits[e.digit*4 +: 4]), 32'(e.value));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    // Drive one dwell of n cycles and queue whatever the bus state should produce.
    task automatic apply(input logic [3:0] a, input logic [6:0] s, input int n);
        evt_t e;
        int   lows;
        int   k;
        int   val;
        an   = a;
        seg  = s;
        lows = 0;
        k    = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                lows++;
                k = i;
            end
        end
        if (n >= SETTLE + 1 && {a, s} != {last_an, last_seg}) begin
            e.is_err = 1'b0;
            e.digit  = k;
            e.value  = 4'h0;
            e.cause  = 2'b00;
            e.cyc    = cyc + SETTLE + 2;
            if (lows >= 2) begin
                e.is_err = 1'b1;
                e.cause  = 2'b10;
                exp_q.push_back(e);
            end else if (lows == 1) begin
                val = -1;
                for (int p = 0; p < 16; p++) begin
                    if (ref_pat[p] == s) val = p;
                end
                if (val >= 0) begin
                    e.value = 4'(val);
                    m_digits[k*4 +: 4] = 4'(val);
                    m_valid[k] = 1'b1;
                    exp_q.push_back(e);
                end else if (s == 7'b1111111) begin
                    m_valid[k] = 1'b0;
                end else begin
                    m_valid[k] = 1'b0;
                    e.is_err = 1'b1;
                    e.cause  = 2'b01;
                    exp_q.push_back(e);
                end
            end
        end
        last_an  = a;
        last_seg = s;
        repeat (n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cap;
        rst_n    = 1'b0;
        an       = 4'hF;
        seg      = 7'h7F;
        m_digits = 16'h0;
        m_valid  = 4'h0;
        last_an  = 4'hF;
        last_seg = 7'h7F;
        repeat (3) step();
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_upd", 32'(upd_pulse), 32'h0);
        check("rst_err", 32'(err_pulse), 32'h0);
        check("rst_cause", 32'(err_cause), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // Reset part-way through a settle window drops the pending capture.
        apply(4'b1101, 7'b0100100, 3);
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        repeat (4) step();
        rst_n    = 1'b1;
        last_an  = 4'hF;
        last_seg = 7'h7F;
        repeat (8) step();
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);

        // Single digit capture with the nominal latency.
        apply(4'b1110, 7'b0110000, 10);
        check("t1_d0", 32'(digits[3:0]), 32'h3);
        check("t1_valid", 32'(valid), 32'b0001);

        // Two digits alternating on the scan.
        for (int r = 0; r < 2; r++) begin
            apply(4'b1110, 7'b1111001, 20);
            apply(4'b0111, 7'b0010010, 20);
        end
        check("t2_d0", 32'(digits[3:0]), 32'h1);
        check("t2_d3", 32'(digits[15:12]), 32'h5);
        check("t2_valid", 32'(valid), 32'b1001);
        check("t2_cause_untouched", 32'(err_cause), 32'h0);

        // Glitch shorter than the settle window is never captured.
        apply(4'b1110, 7'b0000000, 2);
        apply(4'b1110, 7'b1111000, 8);
        check("t3_d0", 32'(digits[3:0]), 32'h7);
        check("t3_valid0", 32'(valid[0]), 32'h1);

        // Two anodes low with an unknown glyph: multi-anode wins, one pulse only.
        apply(4'b0110, 7'b1010101, 10);
        check("t4_digits", 32'(digits), 32'(m_digits));
        check("t4_valid", 32'(valid), 32'(m_valid));
        check("t4_cause", 32'(err_cause), 32'h2);

        // Unknown glyph on d3, then blank on d3.
        apply(4'b0111, 7'b1010101, 10);
        check("t5_valid3_unknown", 32'(valid[3]), 32'h0);
        check("t5_cause_unknown", 32'(err_cause), 32'h1);
        apply(4'b0111, 7'b1111111, 10);
        check("t5_valid3_blank", 32'(valid[3]), 32'h0);
        check("t5_cause_held", 32'(err_cause), 32'h1);

        // Full glyph table across all four positions.
        for (int i = 0; i < 16; i++) begin
            apply(~(4'b0001 << (i % 4)), ref_pat[i], 6);
        end
        check("t6_digits", 32'(digits), 32'hFEDC);
        check("t6_digits_model", 32'(digits), 32'(m_digits));
        check("t6_valid", 32'(valid), 32'hF);

        // Refresh timeout on d0 after the scan stops.
        cap = cyc + SETTLE + 2;
        apply(4'b1110, 7'b0011000, 6);
        check("t7_d0", 32'(digits[3:0]), 32'h9);
        apply(4'hF, 7'h7F, 1);
        while (cyc < cap + TIMEOUT - 1) step();
        check("t7_valid0_before", 32'(valid[0]), 32'h1);
        step();
`ifdef SEGDEC_TIMEOUT_EN
        check("t7_valid0_timeout", 32'(valid[0]), 32'h0);
`else
        check("t7_valid0_no_timeout", 32'(valid[0]), 32'h1);
`endif
        repeat (20) step();
        check("t7_d0_retained", 32'(digits[3:0]), 32'h9);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
